db4_synth_latti: RTL and testbench

Two-channel Daubechies-4 polyphase lattice synthesis (reconstruction) filter bank. It accepts one lowpass/highpass subband pair (g, h) every second clock and rebuilds the full-rate signal y, emitting the even and odd samples on alternate clocks. It sits at the receive end of the DB4 lattice analysis bank and uses the same CSD coefficient approximations, 9-bit subband format and clk/clk2 half-rate phasing.

---
 rtl/db4_pkg.sv | 27 ++
 rtl/db4_csd_coef.sv | 20 ++
 rtl/db4_synth_latti.sv | 67 ++++++
 tb/tb_db4_synth_latti.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/db4_pkg.sv
// db4_pkg: widths, CSD shift constants, phase encoding and output reduction for the DB4 synthesis lattice (DB4SYN_SAT_EN selects saturating output)
package db4_pkg;

    localparam int W_IN   = 9;
    localparam int W_INT  = 20;
    localparam int W_OUT  = 9;
    localparam int SH_1   = 1;
    localparam int SH_2   = 2;
    localparam int SH_6   = 6;
    localparam int SH_8   = 8;
    localparam int SH_OUT = 8;
    localparam int Q_MAX  = 2 ** (W_OUT - 1) - 1;

    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_t;
    typedef enum logic [1:0] {OP_A0, OP_A1, OP_S} coef_op_t;

    function automatic logic signed [W_OUT-1:0] q_out(input logic signed [W_INT-1:0] s);
`ifdef DB4SYN_SAT_EN
        logic signed [W_INT-1:0] t;
        t = s >>> SH_OUT;
        return t > Q_MAX ? W_OUT'(Q_MAX) : t < -Q_MAX - 1 ? W_OUT'(-Q_MAX - 1) : t[W_OUT-1:0];
`else
        return s[SH_OUT+W_OUT-1:SH_OUT];
`endif
    endfunction

endpackage

// File: rtl/db4_csd_coef.sv
// db4_csd_coef: shift-add CSD coefficient multiply (A0 ~1.7305, A1 ~0.2695, S = 124/256) chosen by OP
module db4_csd_coef
    import db4_pkg::*;
#(
    parameter coef_op_t OP = OP_A1
) (
    input  logic signed [W_INT-1:0] v,
    output logic signed [W_INT-1:0] r
);

    logic signed [W_INT-1:0] v2, v6, v8;

    assign v2 = v >>> SH_2;
    assign v6 = v >>> SH_6;
    assign v8 = v >>> SH_8;
    assign r  = OP == OP_A1 ? v2 + v6 + v8 :
                OP == OP_A0 ? (v <<< SH_1) - v2 - (v6 + v8) :
                              (v >>> SH_1) - v6;

endmodule

// File: rtl/db4_synth_latti.sv
// db4_synth_latti: two-channel DB4 lattice synthesis bank, one (g,h) pair per two clocks in, one y per clock out (DB4SYN_SAT_EN clamps y)
module db4_synth_latti
    import db4_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [W_IN-1:0]  g,
    input  logic signed [W_IN-1:0]  h,
    output logic signed [W_OUT-1:0] y,
    output logic                    y_even,
    output logic                    clk2
);

    phase_t phase, phase_nxt;
    logic signed [W_INT-1:0] g_x, h_x, a1_g, a1_h, u0, l0;
    logic signed [W_INT-1:0] u0_reg, u0d, l0_reg, a0_l, a0_u, ye, yo, s_e, s_o;
    logic signed [W_OUT-1:0] yo_hold;

    assign g_x = {{(W_INT-W_IN){g[W_IN-1]}}, g} << SH_OUT;
    assign h_x = {{(W_INT-W_IN){h[W_IN-1]}}, h} << SH_OUT;

    db4_csd_coef #(.OP(OP_A1)) u_a1_h (.v(h_x),    .r(a1_h));
    db4_csd_coef #(.OP(OP_A1)) u_a1_g (.v(g_x),    .r(a1_g));
    db4_csd_coef #(.OP(OP_A0)) u_a0_l (.v(l0_reg), .r(a0_l));
    db4_csd_coef #(.OP(OP_A0)) u_a0_u (.v(u0d),    .r(a0_u));
    db4_csd_coef #(.OP(OP_S))  u_s_e  (.v(ye),     .r(s_e));
    db4_csd_coef #(.OP(OP_S))  u_s_o  (.v(yo),     .r(s_o));

    assign u0   = g_x + a1_h;
    assign l0   = h_x - a1_g;
    assign ye   = u0d - a0_l;
    assign yo   = l0_reg + a0_u;
    assign clk2 = phase;

    // phase register: sampling edge (EVEN) and output edge (ODD) alternate
    always_ff @(posedge clk or posedge reset)
        if (reset) phase <= EVEN;
        else phase <= phase_nxt;

    // next phase: plain toggle, no stall
    always_comb begin
        phase_nxt = EVEN;
        phase_nxt = phase == EVEN ? ODD : EVEN;
    end

    // pipeline: capture stage 1 and delay the upper branch on sampling edges, emit even then held odd sample
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            u0_reg  <= '0;
            u0d     <= '0;
            l0_reg  <= '0;
            yo_hold <= '0;
            y       <= '0;
            y_even  <= 1'b0;
        end else if (phase == EVEN) begin
            u0_reg  <= u0;
            u0d     <= u0_reg;
            l0_reg  <= l0;
            y       <= yo_hold;
            y_even  <= 1'b0;
        end else begin
            y       <= q_out(s_e);
            yo_hold <= q_out(s_o);
            y_even  <= 1'b1;
        end

endmodule

// File: tb/tb_db4_synth_latti.sv
// tb_db4_synth_latti: randomized self-checking bench for db4_synth_latti against an arithmetic reference model
module tb_db4_synth_latti;

    localparam int MAXP = 40;
    localparam int NE   = 2 * MAXP + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [8:0] g = '0, h = '0, y;
    logic y_even, clk2;

    int errs = 0, checks = 0;
    int gq[MAXP], hq[MAXP];
    int oy[NE], oe[NE], oc[NE];
    int xy[NE], xe[NE], xc[NE];

    db4_synth_latti dut (.clk(clk), .reset(reset), .g(g), .h(h), .y(y), .y_even(y_even), .clk2(clk2));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    function automatic int w20(int x);
        logic signed [19:0] t;
        t = x[19:0];
        return int'(t);
    endfunction

    function automatic int a1(int v);
        return w20((v >>> 2) + (v >>> 6) + (v >>> 8));
    endfunction

    function automatic int a0(int v);
        return w20(2 * v - (v >>> 2) - ((v >>> 6) + (v >>> 8)));
    endfunction

    function automatic int qo(int v);
        int t;
        logic signed [8:0] r;
        t = w20((v >>> 1) - (v >>> 6)) >>> 8;
`ifdef DB4SYN_SAT_EN
        return t > 255 ? 255 : t < -256 ? -256 : t;
`else
        r = t[8:0];
        return int'(r);
`endif
    endfunction

    task automatic clear_pairs();
        for (int k = 0; k < MAXP; k++) begin
            gq[k] = 0;
            hq[k] = 0;
        end
    endtask

    // expected y / y_even / clk2 after each edge i (1-based) since reset release
    task automatic model(input int n);
        int up, u, l;
        up = 0;
        xy[1] = 0;
        xe[1] = 0;
        xc[1] = 1;
        for (int k = 0; k < n; k++) begin
            u = w20(gq[k] * 256 + a1(hq[k] * 256));
            l = w20(hq[k] * 256 - a1(gq[k] * 256));
            xy[2*k+2] = qo(w20(up - a0(l)));
            xe[2*k+2] = 1;
            xc[2*k+2] = 0;
            xy[2*k+3] = qo(w20(l + a0(up)));
            xe[2*k+3] = 0;
            xc[2*k+3] = 1;
            up = u;
        end
    endtask

    task automatic restart();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // drives pairs 0..n-1 on sampling edges starting right after a reset release, recording outputs
    task automatic play(input int n, input bit junk);
        for (int i = 1; i <= 2 * n + 1; i++) begin
            if (i % 2 == 1) begin
                g = (i - 1) / 2 < n ? 9'(gq[(i-1)/2]) : 9'sd0;
                h = (i - 1) / 2 < n ? 9'(hq[(i-1)/2]) : 9'sd0;
            end else if (junk) begin
                g = 9'($urandom);
                h = 9'($urandom);
            end
            @(posedge clk);
            #1;
            oy[i] = int'(y);
            oe[i] = int'(y_even);
            oc[i] = int'(clk2);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            g = 9'($urandom);
            h = 9'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (y !== 9'sd0 || y_even !== 1'b0 || clk2 !== 1'b0) begin
                errs++;
                $display("FAIL reset_hold cyc=%0d: got y=%0d y_even=%b clk2=%b, required 0 0 0", c, y, y_even, clk2);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        g = '0;
        h = '0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (clk2 !== 1'(i % 2)) begin
                errs++;
                $display("FAIL reset_clk2 edge=%0d: got %b required %0d", i, clk2, i % 2);
            end
        end
    endtask

    task automatic test_zero();
        clear_pairs();
        restart();
        play(20, 1'b0);
        for (int i = 1; i <= 41; i++) begin
            checks++;
            if (oy[i] != 0 || oe[i] != (i % 2 == 0 ? 1 : 0) || oc[i] != i % 2) begin
                errs++;
                $display("FAIL zero edge=%0d: got y=%0d e=%0d c2=%0d, required 0 %0d %0d", i, oy[i], oe[i], oc[i], i % 2 == 0, i % 2);
            end
        end
    endtask

    task automatic test_impulse();
        int ref_y[10];
        ref_y = '{0, 0, 14, -9, 31, 53, 0, 0, 0, 0};
        clear_pairs();
        gq[0] = 64;
        restart();
        play(4, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            checks++;
            if (oy[i] != ref_y[i] || oe[i] != (i % 2 == 0 ? 1 : 0)) begin
                errs++;
                $display("FAIL impulse edge=%0d: got y=%0d e=%0d, required %0d %0d", i, oy[i], oe[i], ref_y[i], i % 2 == 0);
            end
        end
    endtask

    task automatic test_phase1_ignore();
        clear_pairs();
        restart();
        play(20, 1'b1);
        for (int i = 1; i <= 41; i++) begin
            checks++;
            if (oy[i] != 0 || oc[i] != i % 2) begin
                errs++;
                $display("FAIL phase1_ignore edge=%0d: got y=%0d c2=%0d, required 0 %0d", i, oy[i], oc[i], i % 2);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < MAXP; k++) begin
            gq[k] = int'($urandom_range(0, 511)) - 256;
            hq[k] = int'($urandom_range(0, 511)) - 256;
        end
        model(MAXP);
        restart();
        play(MAXP, 1'b1);
        for (int i = 1; i <= 2 * MAXP + 1; i++) begin
            checks++;
            if (oy[i] != xy[i] || oe[i] != xe[i] || oc[i] != xc[i]) begin
                errs++;
                $display("FAIL random edge=%0d: got y=%0d e=%0d c2=%0d, required %0d %0d %0d", i, oy[i], oe[i], oc[i], xy[i], xe[i], xc[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int odd_ref;
`ifdef DB4SYN_SAT_EN
        odd_ref = 255;
`else
        odd_ref = -151;
`endif
        for (int k = 0; k < MAXP; k++) begin
            gq[k] = k < 6 ? 255 : 0;
            hq[k] = k < 6 ? 255 : 0;
        end
        model(6);
        restart();
        play(6, 1'b0);
        for (int i = 1; i <= 13; i++) begin
            checks++;
            if (oy[i] != xy[i]) begin
                errs++;
                $display("FAIL overflow edge=%0d: got y=%0d required %0d", i, oy[i], xy[i]);
            end
        end
        for (int k = 1; k < 6; k++) begin
            checks++;
            if (oy[2*k+3] != odd_ref) begin
                errs++;
                $display("FAIL overflow_odd pair=%0d: got y=%0d required %0d", k, oy[2*k+3], odd_ref);
            end
        end
    endtask

    task automatic test_mid_reset();
        int ref_y[10];
        ref_y = '{0, 0, 14, -9, 31, 53, 0, 0, 0, 0};
        clear_pairs();
        gq[0] = 64;
        restart();
        play(1, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (y !== 9'sd0 || y_even !== 1'b0 || clk2 !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset_clear: got y=%0d y_even=%b clk2=%b, required 0 0 0", y, y_even, clk2);
        end
        @(negedge clk);
        reset = 1'b0;
        play(4, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            checks++;
            if (oy[i] != ref_y[i] || oc[i] != i % 2) begin
                errs++;
                $display("FAIL mid_reset_restart edge=%0d: got y=%0d c2=%0d, required %0d %0d", i, oy[i], oc[i], ref_y[i], i % 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_impulse();
        test_phase1_ignore();
        test_random();
        test_overflow();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
